mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, block address width.
REQ-002 Parameter BLOCK_W, default 128, block data width.
REQ-003 CLOCK  input  1  single clock; all state updates on posedge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 I_READ  input  1  instruction-side block read request.
REQ-006 I_ADDRESS  input  ADDR_W  instruction-side block address.
REQ-007 I_OUT  output  BLOCK_W  instruction-side read data, registered.
REQ-008 I_BUSYWAIT  output  1  instruction-side stall.
REQ-009 D_READ, D_WRITE  input  1 each  data-side block read/write request.
REQ-010 D_ADDRESS  input  ADDR_W  data-side block address.
REQ-011 D_IN  input  BLOCK_W  data-side write data.
REQ-012 D_OUT  output  BLOCK_W  data-side read data, registered.
REQ-013 D_BUSYWAIT  output  1  data-side stall.
REQ-014 MEM_READ, MEM_WRITE  output  1 each  registered commands to data memory.
REQ-015 MEM_ADDRESS  output  ADDR_W  registered address to memory.
REQ-016 MEM_IN  output  BLOCK_W  registered write data to memory.
REQ-017 MEM_OUT  input  BLOCK_W  memory read data.
REQ-018 MEM_BUSYWAIT  input  1  memory stall; rises with command, falls on completion edge.

Function
REQ-019 States: IDLE, ISSUE, WAIT, DONE; 1-bit GRANT (0=I, 1=D); 1-bit LAST (most recent grant).
REQ-020 Valid request: I_READ; D_READ xor D_WRITE; D_READ&&D_WRITE is illegal and is ignored (never granted, D_BUSYWAIT low).
REQ-021 IDLE: one valid requester -> grant it; both valid -> grant the one not equal to LAST (round-robin); go ISSUE; latch address/data/command into MEM_* registers.
REQ-022 ISSUE: lasts exactly one cycle, MEM_READ or MEM_WRITE high; go WAIT.
REQ-023 WAIT: hold MEM_* stable; on edge sampling MEM_BUSYWAIT==0 go DONE, deassert MEM_READ/MEM_WRITE, capture MEM_OUT into granted requester's OUT on reads only.
REQ-024 DONE: one cycle; update LAST=GRANT; go IDLE.
REQ-025 x_BUSYWAIT = valid request from x AND NOT (state==DONE AND GRANT==x); combinational.
REQ-026 Minimum latency request->BUSYWAIT low: 3 cycles plus memory stall cycles.
REQ-027 Requester holds request and inputs stable until its BUSYWAIT low; changes during grant are ignored (latched copies used).
REQ-028 Writes do not modify D_OUT; I_OUT/D_OUT hold last value between reads.
REQ-029 Request arriving during another grant waits; it wins next IDLE via round-robin.
REQ-030 Request withdrawn before grant: no memory access issued.
REQ-031 At most one memory command active; MEM_READ&&MEM_WRITE never both high.

Reset
REQ-032 RESET high at posedge: state IDLE, LAST=1 (I wins first tie), GRANT=0, MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_IN=0, I_OUT=D_OUT=0.
REQ-033 Reset mid-transaction aborts it; no data captured; BUSYWAITs follow REQ-025 from IDLE.

Structure
REQ-034 State encoding and GRANT_I/GRANT_D constants in shared package mem_pkg with ADDR_W/BLOCK_W defaults.
REQ-035 Sub-module rr_pick (2-way round-robin selector) natural; rest flat.

Verification
REQ-036 After reset, I_READ addr 0x0000010 alone -> MEM_READ high 1 cycle after, I_OUT = memory block, I_BUSYWAIT low exactly one DONE cycle.
REQ-037 I_READ and D_WRITE (addr 0x0000020, D_IN=0x0123..EF) same cycle -> I served first, then D; MEM_IN matches D_IN; D_OUT unchanged.
REQ-038 Both requesting continuously for 4 transactions -> grants alternate I,D,I,D.
REQ-039 D_READ&&D_WRITE both high -> no MEM command, D_BUSYWAIT low.
REQ-040 RESET asserted in WAIT -> next cycle IDLE, MEM_READ=0, OUT registers 0.
REQ-041 Memory stall of 5 cycles -> MEM_ADDRESS/MEM_IN stable throughout, total latency 8 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the two-requester memory arbiter: default widths,
// grant encoding, FSM state type and the round-robin choice helper.
package mem_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int BLOCK_W_DEF = 128;

  // Grant encoding: instruction side is 0, data side is 1.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Pick a requester; on a tie the side that was not served last wins.
  function automatic logic rr_choose(input logic req_i,
                                     input logic req_d,
                                     input logic last);
    logic pick;
    if (req_i && req_d) begin
      pick = ~last;
    end else if (req_d) begin
      pick = GRANT_D;
    end else begin
      pick = GRANT_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector: reports whether anyone is requesting and
// which side should be granted given the most recent grant.
module rr_pick
  import mem_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic valid,
  output logic grant
);

  // Combinational choice; the caller registers the result when it commits.
  always_comb begin
    valid = req_i | req_d;
    grant = rr_choose(req_i, req_d, last);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between an instruction-side and a data-side block requester for a
// single data memory. One memory command is in flight at a time; every
// command goes IDLE -> ISSUE -> WAIT -> DONE and ties alternate round-robin.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_OUT,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_IN,
  output logic [BLOCK_W-1:0] D_OUT,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_IN,
  input  logic [BLOCK_W-1:0] MEM_OUT,
  input  logic               MEM_BUSYWAIT
);

  arb_state_t         state_r, state_s;
  logic               grant_r, grant_s;
  logic               last_r, last_s;
  logic               mem_read_r, mem_read_s;
  logic               mem_write_r, mem_write_s;
  logic [ADDR_W-1:0]  mem_addr_r, mem_addr_s;
  logic [BLOCK_W-1:0] mem_in_r, mem_in_s;
  logic [BLOCK_W-1:0] i_out_r, i_out_s;
  logic [BLOCK_W-1:0] d_out_r, d_out_s;

  logic i_valid_s;
  logic d_valid_s;
  logic pick_valid_s;
  logic pick_grant_s;
  logic done_s;

  // A data request with both read and write set is illegal and never counts.
  assign i_valid_s = I_READ;
  assign d_valid_s = D_READ ^ D_WRITE;
  assign done_s    = (state_r == ST_DONE);

  rr_pick u_rr_pick (
    .req_i (i_valid_s),
    .req_d (d_valid_s),
    .last  (last_r),
    .valid (pick_valid_s),
    .grant (pick_grant_s)
  );

  // Next-state and next-register values; everything holds unless changed.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    last_s      = last_r;
    mem_read_s  = mem_read_r;
    mem_write_s = mem_write_r;
    mem_addr_s  = mem_addr_r;
    mem_in_s    = mem_in_r;
    i_out_s     = i_out_r;
    d_out_s     = d_out_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_s = ST_ISSUE;
          grant_s = pick_grant_s;
          if (pick_grant_s == GRANT_D) begin
            mem_read_s  = D_READ;
            mem_write_s = D_WRITE;
            mem_addr_s  = D_ADDRESS;
            mem_in_s    = D_IN;
          end else begin
            mem_read_s  = 1'b1;
            mem_write_s = 1'b0;
            mem_addr_s  = I_ADDRESS;
            mem_in_s    = mem_in_r;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (!MEM_BUSYWAIT) begin
          state_s     = ST_DONE;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          // Only reads return data; writes leave both OUT registers alone.
          if (mem_read_r && (grant_r == GRANT_D)) begin
            d_out_s = MEM_OUT;
          end else if (mem_read_r) begin
            i_out_s = MEM_OUT;
          end else begin
            d_out_s = d_out_r;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        last_s  = grant_r;
      end
      default: begin
        state_s     = ST_IDLE;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      grant_r     <= GRANT_I;
      last_r      <= GRANT_D;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_in_r    <= {BLOCK_W{1'b0}};
      i_out_r     <= {BLOCK_W{1'b0}};
      d_out_r     <= {BLOCK_W{1'b0}};
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      last_r      <= last_s;
      mem_read_r  <= mem_read_s;
      mem_write_r <= mem_write_s;
      mem_addr_r  <= mem_addr_s;
      mem_in_r    <= mem_in_s;
      i_out_r     <= i_out_s;
      d_out_r     <= d_out_s;
    end
  end

  // Stalls release only during the DONE cycle of the side that was served.
  assign I_BUSYWAIT  = i_valid_s && !(done_s && (grant_r == GRANT_I));
  assign D_BUSYWAIT  = d_valid_s && !(done_s && (grant_r == GRANT_D));

  assign MEM_READ    = mem_read_r;
  assign MEM_WRITE   = mem_write_r;
  assign MEM_ADDRESS = mem_addr_r;
  assign MEM_IN      = mem_in_r;
  assign I_OUT       = i_out_r;
  assign D_OUT       = d_out_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected memory
// commands and expected read data; a monitor compares them as they appear.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int BW = 128;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          I_READ;
  logic [AW-1:0] I_ADDRESS;
  logic [BW-1:0] I_OUT;
  logic          I_BUSYWAIT;
  logic          D_READ;
  logic          D_WRITE;
  logic [AW-1:0] D_ADDRESS;
  logic [BW-1:0] D_IN;
  logic [BW-1:0] D_OUT;
  logic          D_BUSYWAIT;
  logic          MEM_READ;
  logic          MEM_WRITE;
  logic [AW-1:0] MEM_ADDRESS;
  logic [BW-1:0] MEM_IN;
  logic [BW-1:0] MEM_OUT;
  logic          MEM_BUSYWAIT;

  int vectors     = 0;
  int miscompares = 0;
  int stall_cycles = 0;
  int mem_cnt     = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } cmd_t;

  cmd_t          cmd_q[$];
  logic [BW-1:0] i_q[$];
  logic [BW-1:0] d_q[$];
  logic [BW-1:0] d_model;

  // Deterministic memory contents derived from the block address.
  function automatic logic [BW-1:0] block_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {4'h0, a} ^ 32'h5A5A_0000;
    return {w, ~w, w + 32'd1, {4'h0, a}};
  endfunction

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_OUT(I_OUT), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_IN(D_IN),
    .D_OUT(D_OUT), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_IN(MEM_IN), .MEM_OUT(MEM_OUT), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory model: busy from command start for (1 + stall_cycles) edges.
  always @(posedge CLOCK) begin
    if (MEM_READ || MEM_WRITE) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < stall_cycles + 1);
  assign MEM_OUT      = block_of(MEM_ADDRESS);

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares memory commands and completed reads against the queues.
  initial begin : monitor
    logic prev_cmd;
    cmd_t cur;
    prev_cmd = 1'b0;
    cur = '{wr: 1'b0, addr: '0, data: '0};
    forever begin
      @(negedge CLOCK);
      if (MEM_READ || MEM_WRITE) begin
        check("mem_exclusive", BW'(MEM_READ & MEM_WRITE), BW'(1'b0));
        if (!prev_cmd) begin
          if (cmd_q.size() == 0) begin
            check("unexpected_cmd", BW'(1'b1), BW'(1'b0));
          end else begin
            cur = cmd_q.pop_front();
            check("mem_addr", BW'(MEM_ADDRESS), BW'(cur.addr));
            check("mem_write", BW'(MEM_WRITE), BW'(cur.wr));
            if (cur.wr) check("mem_in", MEM_IN, cur.data);
          end
        end else begin
          check("mem_addr_stable", BW'(MEM_ADDRESS), BW'(cur.addr));
          if (cur.wr) check("mem_in_stable", MEM_IN, cur.data);
        end
      end
      if (I_READ && !I_BUSYWAIT) begin
        if (i_q.size() == 0) check("i_unexpected_done", BW'(1'b1), BW'(1'b0));
        else check("i_out", I_OUT, i_q.pop_front());
      end
      if ((D_READ ^ D_WRITE) && !D_BUSYWAIT) begin
        if (d_q.size() == 0) check("d_unexpected_done", BW'(1'b1), BW'(1'b0));
        else check("d_out", D_OUT, d_q.pop_front());
      end
      prev_cmd = MEM_READ || MEM_WRITE;
    end
  end

  // Instruction read; returns cycles from request until I_BUSYWAIT low.
  task automatic i_req(input logic [AW-1:0] a, output int lat);
    I_ADDRESS = a;
    I_READ    = 1'b1;
    lat = 0;
    do begin
      @(posedge CLOCK); #1;
      lat++;
    end while (I_BUSYWAIT && lat < 200);
    if (I_BUSYWAIT) check("i_timeout", BW'(1'b1), BW'(1'b0));
    @(negedge CLOCK); #1;
    I_READ = 1'b0;
  endtask

  // Data read or write; returns cycles from request until D_BUSYWAIT low.
  task automatic d_req(input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] data, output int lat);
    D_ADDRESS = a;
    D_IN      = data;
    D_READ    = ~wr;
    D_WRITE   = wr;
    lat = 0;
    do begin
      @(posedge CLOCK); #1;
      lat++;
    end while (D_BUSYWAIT && lat < 200);
    if (D_BUSYWAIT) check("d_timeout", BW'(1'b1), BW'(1'b0));
    @(negedge CLOCK); #1;
    D_READ  = 1'b0;
    D_WRITE = 1'b0;
  endtask

  task automatic push_cmd(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] data);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = data;
    cmd_q.push_back(c);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    d_model = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    int lat, lat_i, lat_d;
    logic [BW-1:0] wdata;
    RESET = 1'b1; I_READ = 1'b0; I_ADDRESS = '0;
    D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_IN = '0;
    d_model = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    do_reset();

    // Reset state
    check("rst_mem_read",  BW'(MEM_READ),    BW'(1'b0));
    check("rst_mem_write", BW'(MEM_WRITE),   BW'(1'b0));
    check("rst_mem_addr",  BW'(MEM_ADDRESS), BW'(0));
    check("rst_mem_in",    MEM_IN,           BW'(0));
    check("rst_i_out",     I_OUT,            BW'(0));
    check("rst_d_out",     D_OUT,            BW'(0));
    check("rst_i_busy",    BW'(I_BUSYWAIT),  BW'(1'b0));
    check("rst_d_busy",    BW'(D_BUSYWAIT),  BW'(1'b0));

    // Lone instruction read, minimum latency 3
    push_cmd(1'b0, 28'h0000010, '0);
    i_q.push_back(block_of(28'h0000010));
    i_req(28'h0000010, lat);
    check("i_latency", BW'(lat), BW'(3));

    // Simultaneous I read and D write after reset: I first, D_OUT unchanged
    do_reset();
    wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    push_cmd(1'b0, 28'h0000040, '0);
    push_cmd(1'b1, 28'h0000020, wdata);
    i_q.push_back(block_of(28'h0000040));
    d_q.push_back(d_model);
    fork
      i_req(28'h0000040, lat_i);
      d_req(1'b1, 28'h0000020, wdata, lat_d);
    join
    check("d_out_after_write", D_OUT, BW'(0));

    // Continuous requests from both sides alternate I, D, I, D
    push_cmd(1'b0, 28'h0000100, '0);
    push_cmd(1'b0, 28'h0000200, '0);
    push_cmd(1'b0, 28'h0000101, '0);
    push_cmd(1'b0, 28'h0000201, '0);
    i_q.push_back(block_of(28'h0000100));
    i_q.push_back(block_of(28'h0000101));
    d_q.push_back(block_of(28'h0000200));
    d_q.push_back(block_of(28'h0000201));
    d_model = block_of(28'h0000201);
    fork
      begin
        i_req(28'h0000100, lat_i);
        i_req(28'h0000101, lat_i);
      end
      begin
        d_req(1'b0, 28'h0000200, '0, lat_d);
        d_req(1'b0, 28'h0000201, '0, lat_d);
      end
    join

    // Illegal D_READ && D_WRITE: never granted, no stall
    D_ADDRESS = 28'h0000300; D_READ = 1'b1; D_WRITE = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLOCK); #1;
      check("illegal_d_busy",  BW'(D_BUSYWAIT), BW'(1'b0));
      check("illegal_mem_cmd", BW'(MEM_READ | MEM_WRITE), BW'(1'b0));
    end
    D_READ = 1'b0; D_WRITE = 1'b0;

    // Stalled write: latency 3 + 5, MEM_* stable, D_OUT keeps last read
    stall_cycles = 5;
    wdata = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    push_cmd(1'b1, 28'h0000500, wdata);
    d_q.push_back(d_model);
    d_req(1'b1, 28'h0000500, wdata, lat);
    check("stall_latency", BW'(lat), BW'(8));
    check("d_out_kept", D_OUT, block_of(28'h0000201));

    // Reset during WAIT aborts the read and clears the OUT registers
    push_cmd(1'b0, 28'h0000600, '0);
    @(posedge CLOCK); #1;
    I_ADDRESS = 28'h0000600; I_READ = 1'b1;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    check("wait_mem_read", BW'(MEM_READ), BW'(1'b1));
    RESET = 1'b1; I_READ = 1'b0;
    @(posedge CLOCK); #1;
    RESET = 1'b0; d_model = '0;
    stall_cycles = 0;
    check("abort_mem_read", BW'(MEM_READ), BW'(1'b0));
    check("abort_i_out",    I_OUT,         BW'(0));
    check("abort_d_out",    D_OUT,         BW'(0));
    check("abort_mem_addr", BW'(MEM_ADDRESS), BW'(0));

    // Arbiter is back in IDLE: a fresh read sees minimum latency
    push_cmd(1'b0, 28'h0000700, '0);
    i_q.push_back(block_of(28'h0000700));
    i_req(28'h0000700, lat);
    check("post_abort_latency", BW'(lat), BW'(3));

    repeat (3) @(posedge CLOCK);
    #1;
    check("cmd_q_drained", BW'(cmd_q.size()), BW'(0));
    check("i_q_drained",   BW'(i_q.size()),   BW'(0));
    check("d_q_drained",   BW'(d_q.size()),   BW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
